// File: rtl/uart_tx_arb.sv
// Two-requester arbiter in front of a UART transmitter: round-robin with an
// optional packet lock, one-cycle start pulse, and a start-to-busy watchdog.
module uart_tx_arb #(
    parameter int TMO = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_lock,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_lock,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    state_t        state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [1:0]    grant_q, grant_d;
    logic          err_q, err_d;
    logic          lock_q, lock_d;
    logic          lock_own_q, lock_own_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win;

    // A held lock pins the winner even when its owner is not valid, which
    // is what keeps the other requester out mid-packet.
    always_comb begin
        win = ~last_q;
        if (lock_q)
            win = lock_own_q;
        else if (req0_valid && !req1_valid)
            win = 1'b0;
        else if (req1_valid && !req0_valid)
            win = 1'b1;
    end

    assign req0_ready = rst && (state_q == IDLE) && !win && req0_valid;
    assign req1_ready = rst && (state_q == IDLE) &&  win && req1_valid;
    assign tx_start   = (state_q == START);
    assign tx_data    = tx_data_q;
    assign grant      = grant_q;
    assign err        = err_q;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        err_d      = 1'b0;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    tx_data_d  = win ? req1_data : req0_data;
                    grant_d    = win ? 2'b10 : 2'b01;
                    last_d     = win;
                    lock_d     = win ? req1_lock : req0_lock;
                    lock_own_d = win;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Timeout drops the byte but leaves the lock untouched.
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            grant_q    <= 2'b00;
            err_q      <= 1'b0;
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-low, named rst.
REQ-002 Ports SHALL be, clock and reset first:
  clk  in  1  system clock, all state on rising edge
  rst  in  1  synchronous active-low reset
  req0_valid  in  1  requester 0 has a byte
  req0_data  in  8  requester 0 byte
  req0_lock  in  1  keep grant after this byte (packet mode)
  req0_ready  out  1  requester 0 byte accepted this cycle
  req1_valid / req1_data / req1_lock / req1_ready  same as requester 0, for requester 1
  tx_start  out  1  one-cycle start pulse to the UART transmitter
  tx_data  out  8  byte to the UART transmitter, held stable from start until done
  tx_busy  in  1  transmitter busy, rises the cycle after tx_start
  grant  out  2  one-hot owner of the byte in flight; 00 when idle
  err  out  1  one-cycle pulse on start timeout
REQ-003 There SHALL be one parameter: TMO, default 4, the number of cycles allowed for tx_busy to rise after tx_start.

Function
REQ-004 States SHALL be IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-005 In IDLE, the winner SHALL be chosen as follows:
  - If a lock is held by N, only N is eligible.
  - Otherwise, if exactly one requester is valid, that requester wins.
  - If both are valid, the requester not served last wins (round-robin).
  - After reset, requester 0 counts as served last.
REQ-006 reqN_ready SHALL be combinational: high only when state==IDLE, N is the winner and reqN_valid==1; it SHALL be low in every other state.
REQ-007 On an accept edge (valid&ready), the block SHALL:
  - capture tx_data<=reqN_data;
  - set grant to N;
  - record N as last served;
  - set or clear the lock to reqN_lock;
  - go to START.
REQ-008 In START, tx_start SHALL be 1 for exactly one cycle, then the block SHALL go to WAIT_BUSY; tx_start SHALL be 0 in all other states.
REQ-009 In WAIT_BUSY, the block SHALL:
  - go to WAIT_DONE when tx_busy==1;
  - when TMO cycles elapse without tx_busy, pulse err for one cycle, clear grant and go to IDLE.
REQ-010 In WAIT_DONE, the block SHALL stay until tx_busy==0, then clear grant and go to IDLE.
REQ-011 Minimum spacing between tx_start pulses SHALL be 4 cycles beyond the busy interval (IDLE, START, WAIT_BUSY, WAIT_DONE exit); there is no back-to-back start.
REQ-012 While locked to N and reqN_valid==0, the block SHALL remain in IDLE and SHALL NOT serve the other requester.
REQ-013 A timeout SHALL NOT clear the lock; it drops the byte, and that byte SHALL NOT be retried.
REQ-014 Valid dropping before acceptance SHALL be legal; no byte is lost or duplicated.
REQ-015 tx_data SHALL change only on an accept edge.

Reset
REQ-016 When rst==0 at a clock edge, the block SHALL:
  - force state IDLE, tx_start=0, tx_data=0, grant=00, err=0;
  - clear the lock;
  - set last-served to requester 0.
REQ-017 Reset SHALL abort any transfer in progress, with no err pulse.
REQ-018 During reset, req0_ready and req1_ready SHALL be 0.

Verification
REQ-019 Single requester: req0 sends 0x55; with tx_busy high 3 cycles after start -> tx_start pulses once, tx_data=0x55, grant=01 until busy falls, then 00.
REQ-020 Contention: both valid from reset with 0xA1/0xB2 -> order 0xB2 (req1), 0xA1, 0xB2, 0xA1 while both stay valid.
REQ-021 Lock: req0 sends 0x10(lock=1), 0x11(lock=1), 0x12(lock=0) with req1 always valid -> tx order 0x10, 0x11, 0x12, then req1's byte; req1_ready never high during the packet.
REQ-022 Timeout: tx_busy tied 0 -> err pulses exactly 5 cycles after the tx_start cycle, block returns to IDLE, next request is accepted.
REQ-023 Reset mid-transfer: assert rst in WAIT_DONE -> next cycle all outputs at reset values, lock cleared, no err.
REQ-024 Model check: no tx_start while tx_busy==1; tx_data stable from start until grant clears; ready one-hot or zero.
